gcm_ghash_engine: RTL and testbench
===================================

# gcm_ghash_engine

Parametrised, multi-channel GHASH/tag engine for the AES-GCM datapath. It replaces the fixed single-instance tag stage with a digit-serial GF(2^128) multiplier whose digit width is set at build time. Each channel holds its own hash subkey H and GHASH accumulator. On the last block of a message it emits GHASH ⊕ E(K,J0) as the tag, plus a compare flag for decrypt-side verification. It sits downstream of the AES counter pipeline, taking AAD, ciphertext and length blocks.

## Interface
- DIGIT_W, 8: multiplier bits consumed per cycle; legal values 1, 2, 4, 8, 16, 32, 64, 128.
- NUM_CH, 4: number of independent GHASH contexts (≥1); CH_W = max(1, $clog2(NUM_CH)).
- clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_h_load  in  1  load i_h into channel i_h_ch; accepted every cycle.
- i_h_ch  in  CH_W  channel for H load.
- i_h  in  [0:127]  hash subkey H = E(K, 0^128).
- i_valid  in  1  block offered.
- o_ready  out  1  engine idle; block accepted on edge with i_valid && o_ready.
- i_ch  in  CH_W  channel of offered block.
- i_block  in  [0:127]  AAD/ciphertext/length block, bit 0 = GCM bit 0 (MSB of first byte).
- i_first  in  1  block starts a message; accumulator treated as zero.
- i_last  in  1  block is the length block; produce tag.
- i_mask  in  [0:127]  E(K,J0); sampled with i_last block.
- i_ref_tag  in  [0:127]  expected tag; sampled on accept.
- o_tag_valid  out  1  one-cycle pulse, tag outputs valid.
- o_tag_ch  out  CH_W  channel of emitted tag.
- o_tag  out  [0:127]  GHASH ⊕ mask.
- o_tag_match  out  1  o_tag == sampled i_ref_tag.

## Operation
- N = 128/DIGIT_W multiply cycles per block.
- FSM: IDLE (o_ready=1) → MUL on accept; MUL counts digits 0..N-1; on final digit edge, write back and return to IDLE.
- On accept, latch: X = (i_first ? 0 : Y[i_ch]) ⊕ i_block; V = H[i_ch]; Z = 0; ch, last, mask, ref.
- Per MUL cycle, unrolled DIGIT_W times over X bits i (MSB-first, bit 0 first): if X[i], Z ^= V; V = V[127] ? (V>>1) ⊕ R : V>>1, where R = 0xE1 followed by 120 zero bits.
- Writeback edge: Y[ch] ← Z. If last: o_tag ← Z ⊕ mask, o_tag_match ← (Z ⊕ mask == ref), o_tag_ch ← ch, o_tag_valid ← 1 for one cycle. Non-last blocks produce no tag.
- Y[ch] keeps its final GHASH after last; only i_first restarts it. i_first && i_last together forms a valid single-block message.
- H load: H[i_h_ch] ← i_h and Y[i_h_ch] ← 0. An in-flight multiply keeps its latched V.
- Same-edge H load and writeback to the same channel: the writeback value of Y wins, and H is still updated.
- Same-edge H load and block accept on the same channel: the block uses the old H.
- i_ch ≥ NUM_CH: block is accepted, and the result is discarded (no writeback, no tag).

## Timing
- Reset values: o_ready 0 while i_rst is high, 1 from the first cycle after; o_tag_valid 0, o_tag 0, o_tag_ch 0, o_tag_match 0; all H and Y 0; FSM IDLE; digit counter 0.
- Latency: block accepted at edge e; o_tag_valid is high in the cycle after edge e+N, and o_ready is high in that same cycle.
- Throughput: one block per N+1 cycles. The next accept can occur at edge e+N+1.
- o_ready depends on state only, never on i_valid.
- Reset mid-MUL: abort, no writeback, no tag pulse.

## Structure
- Package gcm_pkg: typedef block_t logic [0:127]; localparam GCM_R = 128'hE1 << 120; helper function gf_shift_r(block_t) applying one reduction step.
- Sub-module gcm_gf_digit_step: combinational, DIGIT_W unrolled iterations (inputs Z, V, digit; outputs Z', V'). The engine instantiates it once. The engine holds FSM, counter, context arrays and output registers.

## Test plan
- Reset, then H load ch0 with 66e94bd4ef8a2c3b884cfa59ca342b2e; block 0 with first=last=1, mask 58e2fccefa7e3061367f1d57a4e7455a → o_tag 58e2fccefa7e3061367f1d57a4e7455a after N cycles; o_tag_match=1 when ref equals it.
- Same H; block 0388dace60b6a392f328c2b971b2fe78 (first=1), then 00000000000000000000000000000080 (last=1), same mask → tag ab6e47d42cec13bdf53a67b21257bddf. Repeat for DIGIT_W = 1, 8 and 128; check latencies 128, 16 and 1.
- Interleave the blocks above on ch1 and ch2 with different H → each channel's tag matches the golden model; no cross-contamination.
- Corrupt one ref_tag bit → o_tag_match=0 while o_tag is unchanged.
- Assert i_rst midway through MUL → no o_tag_valid; o_ready is 1 the cycle after reset drops; Y of all channels reads 0 (re-run the first test).
- Hold i_valid continuously → accepts spaced exactly N+1 cycles apart; H load on the busy channel mid-multiply leaves the current result unchanged.

Source files
------------

// File: rtl/gcm_pkg.sv
// gcm_pkg: shared types, constants and helpers for the GHASH engine.
//   block_t     128-bit GCM block, index 0 = GCM bit 0 (MSB of first byte)
//   state_e     engine FSM states
//   GCM_R       reduction constant 11100001 || 0^120
//   gf_shift_r  one "multiply by x" step in GCM's reflected bit order
package gcm_pkg;

  typedef logic [0:127] block_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam block_t GCM_R = 128'hE1 << 7'd120;

  // Shift toward higher GCM bit index; reduce when the x^127 term falls off.
  function automatic block_t gf_shift_r(input block_t v);
    return v[127] ? ((v >> 1'b1) ^ GCM_R) : (v >> 1'b1);
  endfunction

endpackage

// File: rtl/gcm_gf_digit_step.sv
// gcm_gf_digit_step: combinational slice of the shift-and-add GF(2^128)
// multiplier. Consumes DIGIT_W multiplier bits per evaluation.
//   z_i / z_o      partial product in / out
//   v_i / v_o      running multiplicand H * x^k in / out
//   digit_i        next DIGIT_W bits of X, digit_i[0] processed first
module gcm_gf_digit_step
  import gcm_pkg::*;
#(
  parameter int DIGIT_W = 8
) (
  input  block_t               z_i,
  input  block_t               v_i,
  input  logic [0:DIGIT_W-1]   digit_i,
  output block_t               z_o,
  output block_t               v_o
);

  block_t z_acc_s;
  block_t v_acc_s;

  // Unrolled conditional-accumulate / shift chain over the digit bits.
  always_comb begin
    z_acc_s = z_i;
    v_acc_s = v_i;
    for (int j = 0; j < DIGIT_W; j++) begin
      if (digit_i[j]) begin
        z_acc_s = z_acc_s ^ v_acc_s;
      end else begin
        z_acc_s = z_acc_s;
      end
      v_acc_s = gf_shift_r(v_acc_s);
    end
  end

  assign z_o = z_acc_s;
  assign v_o = v_acc_s;

endmodule

// File: rtl/gcm_ghash_engine.sv
// gcm_ghash_engine: multi-channel digit-serial GHASH / GCM tag engine.
//   clk, i_rst                         clock, synchronous active-high reset
//   i_h_load, i_h_ch, i_h              per-channel hash subkey load (clears Y)
//   i_valid, o_ready, i_ch, i_block    block handshake; one block per N+1 cycles
//   i_first, i_last                    message start / length block
//   i_mask, i_ref_tag                  E(K,J0) and expected tag, sampled on accept
//   o_tag_valid, o_tag_ch, o_tag,
//   o_tag_match                        one-cycle tag result after the last block
module gcm_ghash_engine
  import gcm_pkg::*;
#(
  parameter int  DIGIT_W = 8,
  parameter int  NUM_CH  = 4,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_h_load,
  input  logic [CH_W-1:0] i_h_ch,
  input  logic [0:127]    i_h,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [CH_W-1:0] i_ch,
  input  logic [0:127]    i_block,
  input  logic            i_first,
  input  logic            i_last,
  input  logic [0:127]    i_mask,
  input  logic [0:127]    i_ref_tag,
  output logic            o_tag_valid,
  output logic [CH_W-1:0] o_tag_ch,
  output logic [0:127]    o_tag,
  output logic            o_tag_match
);

  localparam int                N        = 128 / DIGIT_W;
  localparam int                CNT_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q;

  block_t            h_q [NUM_CH];
  block_t            y_q [NUM_CH];

  block_t            x_q, z_q, v_q, mask_q, ref_q;
  logic [CH_W-1:0]   ch_q;
  logic              ch_ok_q, last_q;

  logic              tag_valid_q, tag_match_q;
  logic [CH_W-1:0]   tag_ch_q;
  block_t            tag_q;

  logic              accept_s, done_s, in_ch_ok_s, h_ch_ok_s;
  block_t            y_sel_s, h_sel_s, z_step_s, v_step_s, tag_s;

  assign accept_s   = i_valid && ready_q;
  assign done_s     = (state_q == ST_MUL) && (cnt_q == CNT_LAST);
  assign in_ch_ok_s = ({1'b0, i_ch}   < (CH_W + 1)'(NUM_CH));
  assign h_ch_ok_s  = ({1'b0, i_h_ch} < (CH_W + 1)'(NUM_CH));
  assign tag_s      = z_step_s ^ mask_q;

  // Context lookup for the offered block; out-of-range channels read zero.
  always_comb begin
    y_sel_s = '0;
    h_sel_s = '0;
    if (in_ch_ok_s) begin
      y_sel_s = y_q[i_ch];
      h_sel_s = h_q[i_ch];
    end else begin
      y_sel_s = '0;
      h_sel_s = '0;
    end
  end

  gcm_gf_digit_step #(
    .DIGIT_W (DIGIT_W)
  ) u_step (
    .z_i     (z_q),
    .v_i     (v_q),
    .digit_i (x_q[0:DIGIT_W-1]),
    .z_o     (z_step_s),
    .v_o     (v_step_s)
  );

  // FSM next-state and digit counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_MUL;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state, counter and ready flag; ready mirrors the next state.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_IDLE);
    end
  end

  // Contexts, multiply datapath and tag outputs. Writeback is placed after
  // the H-load so a same-edge writeback to Y overrides the load's clear.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        h_q[c] <= '0;
        y_q[c] <= '0;
      end
      x_q         <= '0;
      z_q         <= '0;
      v_q         <= '0;
      mask_q      <= '0;
      ref_q       <= '0;
      ch_q        <= '0;
      ch_ok_q     <= 1'b0;
      last_q      <= 1'b0;
      tag_valid_q <= 1'b0;
      tag_match_q <= 1'b0;
      tag_ch_q    <= '0;
      tag_q       <= '0;
    end else begin
      tag_valid_q <= 1'b0;
      if (i_h_load && h_ch_ok_s) begin
        h_q[i_h_ch] <= i_h;
        y_q[i_h_ch] <= '0;
      end
      if (accept_s) begin
        x_q     <= (i_first ? '0 : y_sel_s) ^ i_block;
        v_q     <= h_sel_s;
        z_q     <= '0;
        ch_q    <= i_ch;
        ch_ok_q <= in_ch_ok_s;
        last_q  <= i_last;
        mask_q  <= i_mask;
        ref_q   <= i_ref_tag;
      end else if (state_q == ST_MUL) begin
        x_q <= x_q << DIGIT_W;
        z_q <= z_step_s;
        v_q <= v_step_s;
        if (done_s && ch_ok_q) begin
          y_q[ch_q] <= z_step_s;
          if (last_q) begin
            tag_valid_q <= 1'b1;
            tag_q       <= tag_s;
            tag_ch_q    <= ch_q;
            tag_match_q <= (tag_s == ref_q);
          end
        end
      end
    end
  end

  assign o_ready     = ready_q;
  assign o_tag_valid = tag_valid_q;
  assign o_tag_ch    = tag_ch_q;
  assign o_tag       = tag_q;
  assign o_tag_match = tag_match_q;

endmodule

// File: tb/tb_gcm_ghash_engine.sv
// Bench for gcm_ghash_engine: three instances (DIGIT_W = 1, 8, 128) share
// clock and reset; a polynomial-arithmetic GHASH model predicts every tag.
module tb_gcm_ghash_engine;

  localparam int NI  = 3;
  localparam int NCH = 4;

  localparam logic [127:0] H0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] M0 = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C0 = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] L0 = 128'h00000000000000000000000000000080;
  localparam logic [127:0] T0 = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         h_load [NI];
  logic [1:0]   h_ch   [NI];
  logic [127:0] h_v    [NI];
  logic         valid  [NI];
  logic         ready  [NI];
  logic [1:0]   ch     [NI];
  logic [127:0] blk    [NI];
  logic         first  [NI];
  logic         last   [NI];
  logic [127:0] mask   [NI];
  logic [127:0] reft   [NI];
  logic         tv     [NI];
  logic [1:0]   tch    [NI];
  logic [127:0] tag    [NI];
  logic         tm     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    gcm_ghash_engine #(
      .DIGIT_W ((g == 0) ? 1 : ((g == 1) ? 8 : 128)),
      .NUM_CH  (NCH)
    ) u_dut (
      .clk         (clk),
      .i_rst       (rst),
      .i_h_load    (h_load[g]),
      .i_h_ch      (h_ch[g]),
      .i_h         (h_v[g]),
      .i_valid     (valid[g]),
      .o_ready     (ready[g]),
      .i_ch        (ch[g]),
      .i_block     (blk[g]),
      .i_first     (first[g]),
      .i_last      (last[g]),
      .i_mask      (mask[g]),
      .i_ref_tag   (reft[g]),
      .o_tag_valid (tv[g]),
      .o_tag_ch    (tch[g]),
      .o_tag       (tag[g]),
      .o_tag_match (tm[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] mh [NI][NCH];
  logic [127:0] my [NI][NCH];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int nlat(input int k);
    return (k == 0) ? 128 : ((k == 1) ? 16 : 1);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] rev128(input logic [127:0] a);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = a[127-i];
    return r;
  endfunction

  // GF(2^128) product as ordinary polynomials: GCM bit i is the x^i coefficient.
  // Carry-less multiply, then reduce modulo x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ap, bp;
    logic [254:0] p, bw, poly;
    ap = rev128(a);
    bp = rev128(b);
    bw = {127'd0, bp};
    poly = {247'd0, 8'h87};
    p = '0;
    for (int i = 0; i < 128; i++)
      if (ap[i]) p = p ^ (bw << i);
    for (int i = 254; i >= 128; i--)
      if (p[i]) p = p ^ (poly << (i - 128)) ^ (255'd1 << i);
    return rev128(p[127:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_h(input int k, input int c, input logic [127:0] hv);
    h_load[k] = 1'b1;
    h_ch[k]   = 2'(c);
    h_v[k]    = hv;
    step();
    h_load[k] = 1'b0;
    mh[k][c]  = hv;
    my[k][c]  = '0;
  endtask

  task automatic send(input int k, input int c, input logic [127:0] b, input logic f,
                      input logic l, input logic [127:0] mk, input logic [127:0] rf,
                      input string name, output logic [127:0] got);
    int t;
    logic seen;
    logic [127:0] z, exp_tag;
    t = 0;
    while (!ready[k] && t < 400) begin
      step();
      t++;
    end
    check({name, "_ready"}, 128'(ready[k]), 128'd1);
    z = gf_mul((f ? 128'd0 : my[k][c]) ^ b, mh[k][c]);
    my[k][c] = z;
    exp_tag = z ^ mk;
    valid[k] = 1'b1; ch[k] = 2'(c); blk[k] = b; first[k] = f; last[k] = l;
    mask[k] = mk; reft[k] = rf;
    step();
    valid[k] = 1'b0;
    got = tag[k];
    if (l) begin
      t = 0;
      while (!tv[k] && t < nlat(k) + 8) begin
        step();
        t++;
      end
      check({name, "_lat"}, 128'(t), 128'(nlat(k)));
      check({name, "_tag"}, tag[k], exp_tag);
      check({name, "_match"}, 128'(tm[k]), 128'(exp_tag == rf));
      check({name, "_ch"}, 128'(tch[k]), 128'(c));
      check({name, "_rdy_done"}, 128'(ready[k]), 128'd1);
      got = tag[k];
    end else begin
      seen = 1'b0;
      for (int i = 0; i < nlat(k); i++) begin
        step();
        seen = seen | tv[k];
      end
      check({name, "_notag"}, 128'(seen), 128'd0);
      check({name, "_rdy_done"}, 128'(ready[k]), 128'd1);
    end
  endtask

  initial begin : main
    logic [127:0] got, h1, h2, hn, exp_last, rb;
    logic seen;
    logic [127:0] bl [4];
    int acc_cyc [4];
    int cyc, idx, t;
    logic acc, hl;

    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      h_load[k] = 1'b0; h_ch[k] = '0; h_v[k] = '0; valid[k] = 1'b0; ch[k] = '0;
      blk[k] = '0; first[k] = 1'b0; last[k] = 1'b0; mask[k] = '0; reft[k] = '0;
      for (int c = 0; c < NCH; c++) begin
        mh[k][c] = '0;
        my[k][c] = '0;
      end
    end
    step(); step(); step();
    for (int k = 0; k < NI; k++) check("rst_ready_low", 128'(ready[k]), 128'd0);
    rst = 1'b0;
    step();
    for (int k = 0; k < NI; k++) begin
      check("rst_ready_high", 128'(ready[k]), 128'd1);
      check("rst_tv", 128'(tv[k]), 128'd0);
      check("rst_tag", tag[k], 128'd0);
      check("rst_match", 128'(tm[k]), 128'd0);
      check("rst_tch", 128'(tch[k]), 128'd0);
    end

    // Known-answer vectors on every digit width.
    for (int k = 0; k < NI; k++) begin
      load_h(k, 0, H0);
      send(k, 0, 128'd0, 1'b1, 1'b1, M0, M0, "kat1", got);
      check("kat1_gold", got, M0);
      send(k, 0, C0, 1'b1, 1'b0, M0, 128'd0, "kat2a", got);
      send(k, 0, L0, 1'b0, 1'b1, M0, T0, "kat2b", got);
      check("kat2_gold", got, T0);
    end

    // Interleaved messages on two channels with independent random subkeys.
    h1 = rnd128();
    h2 = rnd128();
    load_h(1, 1, h1);
    load_h(1, 2, h2);
    send(1, 1, rnd128(), 1'b1, 1'b0, M0, 128'd0, "il_c1a", got);
    send(1, 2, rnd128(), 1'b1, 1'b0, M0, 128'd0, "il_c2a", got);
    send(1, 1, rnd128(), 1'b0, 1'b0, M0, 128'd0, "il_c1b", got);
    send(1, 2, L0, 1'b0, 1'b1, M0, 128'd0, "il_c2z", got);
    send(1, 1, L0, 1'b0, 1'b1, M0, 128'd0, "il_c1z", got);

    // Corrupted reference: match drops, tag is unaffected.
    load_h(1, 3, H0);
    send(1, 3, C0, 1'b1, 1'b0, M0, 128'd0, "bad_a", got);
    send(1, 3, L0, 1'b0, 1'b1, M0, T0 ^ (128'd1 << $urandom_range(127, 0)), "bad_b", got);
    check("bad_tag", got, T0);
    check("bad_match", 128'(tm[1]), 128'd0);

    // Reset in the middle of a multiply on the 1-bit engine.
    valid[0] = 1'b1; ch[0] = 2'd0; blk[0] = rnd128(); first[0] = 1'b0; last[0] = 1'b1;
    step();
    valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    check("mid_rst_ready_low", 128'(ready[0]), 128'd0);
    rst = 1'b0;
    for (int k = 0; k < NI; k++)
      for (int c = 0; c < NCH; c++) begin
        mh[k][c] = '0;
        my[k][c] = '0;
      end
    seen = tv[0];
    step();
    for (int k = 0; k < NI; k++) check("mid_rst_ready", 128'(ready[k]), 128'd1);
    for (int i = 0; i < 140; i++) begin
      seen = seen | tv[0];
      step();
    end
    check("mid_rst_notag", 128'(seen), 128'd0);
    load_h(0, 0, H0);
    rb = rnd128();
    send(0, 0, rb, 1'b0, 1'b1, M0, 128'd0, "post_rst", got);
    send(0, 0, 128'd0, 1'b1, 1'b1, M0, M0, "post_rst_kat1", got);
    check("post_rst_gold", got, M0);

    // Back-to-back blocks with i_valid held; subkey reload mid-multiply.
    hn = rnd128();
    load_h(1, 2, rnd128());
    for (int i = 0; i < 4; i++) bl[i] = rnd128();
    for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
    valid[1] = 1'b1; ch[1] = 2'd2; blk[1] = bl[0]; first[1] = 1'b1; last[1] = 1'b0;
    mask[1] = M0; reft[1] = 128'd0;
    cyc = 0; idx = 0; exp_last = '0;
    while (idx < 4 && cyc < 400) begin
      acc = ready[1];
      if (acc) begin
        my[1][2] = gf_mul((first[1] ? 128'd0 : my[1][2]) ^ blk[1], mh[1][2]);
        if (idx == 3) exp_last = my[1][2] ^ M0;
        acc_cyc[idx] = cyc;
        idx++;
      end
      // Writeback of the in-flight block overrides the reload's clear of Y.
      hl = !acc && (idx == 2) && (cyc == acc_cyc[1] + 5);
      if (hl) begin
        h_load[1] = 1'b1; h_ch[1] = 2'd2; h_v[1] = hn;
      end
      step();
      cyc++;
      if (hl) begin
        h_load[1] = 1'b0;
        mh[1][2] = hn;
      end
      if (acc) begin
        if (idx < 4) begin
          blk[1] = bl[idx]; first[1] = 1'b0; last[1] = (idx == 3);
        end else begin
          valid[1] = 1'b0;
        end
      end
    end
    check("bb_count", 128'(idx), 128'd4);
    for (int i = 1; i < 4; i++) check("bb_spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd17);
    t = 0;
    while (!tv[1] && t < 40) begin
      step();
      t++;
    end
    check("bb_lat", 128'(t), 128'd16);
    check("bb_tag", tag[1], exp_last);
    check("bb_ch", 128'(tch[1]), 128'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
